axi_rt_bw_monitor: RTL and testbench

- Passive per-manager bandwidth monitor on the downstream (manager) side of one real-time unit port, i.e. it snoops one mst_req_o/mst_resp_i pair.
- Counts read-data and write-data bytes within a programmable cycle window.
- At each window end it latches the totals and flags threshold overruns.
- Never drives AXI signals; it gives software a measured view of what budgets actually let through.

---
 rtl/axi_rt_bw_mon_pkg.sv | 29 ++
 rtl/axi_rt_bw_counter.sv | 55 +++++
 rtl/axi_rt_bw_monitor.sv | 146 ++++++++++++++
 tb/tb_axi_rt_bw_monitor.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rt_bw_mon_pkg.sv
// Shared types and helpers for the real-time port bandwidth monitor.
// Default snoop structs carry only the handshake and strobe fields the monitor reads.
package axi_rt_bw_mon_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mon_state_e;

    typedef struct packed {
        logic [7:0] strb;
    } mon_w_chan_t;

    typedef struct packed {
        mon_w_chan_t w;
        logic        w_valid;
        logic        r_ready;
    } mon_req_t;

    typedef struct packed {
        logic w_ready;
        logic r_valid;
    } mon_resp_t;

    function automatic int unsigned bytes_per_beat(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/axi_rt_bw_counter.sv
// Per-channel byte counter: saturating window accumulator, closed-window latch,
// threshold compare and sticky overrun flag.
module axi_rt_bw_counter #(
    parameter int unsigned CountWidth = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  run_i,
    input  logic                  beat_i,
    input  logic                  close_i,
    input  logic                  clear_i,
    input  logic [CountWidth-1:0] inc_i,
    input  logic [CountWidth-1:0] thresh_i,
    output logic [CountWidth-1:0] bytes_o,
    output logic                  overrun_o
);

    logic [CountWidth-1:0] run_q;
    logic [CountWidth-1:0] bytes_q;
    logic                  over_q;
    logic [CountWidth-1:0] beat_inc;
    logic [CountWidth:0]   sum;
    logic [CountWidth-1:0] run_total;
    logic                  over_set;

    always_comb begin
        beat_inc  = beat_i ? inc_i : '0;
        sum       = {1'b0, run_q} + {1'b0, beat_inc};
        run_total = sum[CountWidth] ? '1 : sum[CountWidth-1:0];
        over_set  = run_i && (thresh_i != '0) && (run_total > thresh_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_q   <= '0;
            bytes_q <= '0;
            over_q  <= 1'b0;
        end else begin
            // Idle or a closing window both leave the accumulator at zero.
            if (!run_i || close_i) begin
                run_q <= '0;
            end else begin
                run_q <= run_total;
            end
            if (close_i) begin
                bytes_q <= run_total;
            end
            over_q <= over_set | (over_q & ~clear_i);
        end
    end

    assign bytes_o   = bytes_q;
    assign overrun_o = over_q;

endmodule

// File: rtl/axi_rt_bw_monitor.sv
// Passive read/write byte-rate monitor over a programmable cycle window.
// Optional AXI_RT_BW_MON_STRB_EN: write beats count set strobe bits instead of full width.
module axi_rt_bw_monitor
    import axi_rt_bw_mon_pkg::*;
#(
    parameter int unsigned DataWidth   = 64,
    parameter int unsigned WindowWidth = 32,
    parameter int unsigned CountWidth  = 32,
    parameter type         axi_req_t   = mon_req_t,
    parameter type         axi_resp_t  = mon_resp_t
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  axi_req_t               req_i,
    input  axi_resp_t              resp_i,
    input  logic                   enable_i,
    input  logic [WindowWidth-1:0] window_i,
    input  logic [CountWidth-1:0]  r_thresh_i,
    input  logic [CountWidth-1:0]  w_thresh_i,
    input  logic                   clear_i,
    output logic                   active_o,
    output logic                   window_done_o,
    output logic [CountWidth-1:0]  r_bytes_o,
    output logic [CountWidth-1:0]  w_bytes_o,
    output logic                   r_overrun_o,
    output logic                   w_overrun_o
);

    localparam int unsigned BytesPerBeat = bytes_per_beat(DataWidth);

    mon_state_e             state_q, state_d;
    logic [WindowWidth-1:0] win_len_q;
    logic [WindowWidth-1:0] win_cnt_q;
    logic                   done_q;
    logic                   start;
    logic                   close;
    logic                   running;
    logic                   r_beat;
    logic                   w_beat;
    logic [CountWidth-1:0]  r_inc;
    logic [CountWidth-1:0]  w_inc;
    logic                   unused_snoop;

    assign r_beat  = resp_i.r_valid & req_i.r_ready;
    assign w_beat  = req_i.w_valid & resp_i.w_ready;
    assign running = (state_q == RUN) && enable_i;
    assign r_inc   = CountWidth'(BytesPerBeat);

`ifdef AXI_RT_BW_MON_STRB_EN
    always_comb begin
        w_inc = '0;
        for (int unsigned i = 0; i < $bits(req_i.w.strb); i++) begin
            w_inc = w_inc + CountWidth'(req_i.w.strb[i]);
        end
    end
`else
    assign w_inc = CountWidth'(BytesPerBeat);
`endif

    // Snooped struct fields the monitor never looks at.
    assign unused_snoop = ^{req_i, resp_i};

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        close   = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_i && (window_i != '0)) begin
                    state_d = RUN;
                    start   = 1'b1;
                end
            end
            RUN: begin
                if (!enable_i) begin
                    state_d = IDLE;
                end else if (win_cnt_q == win_len_q - WindowWidth'(1)) begin
                    close = 1'b1;
                    if (window_i == '0) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // window_i is only sampled at entry and at window boundaries.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            win_len_q <= '0;
            win_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= close;
            if (start || close) begin
                win_len_q <= window_i;
                win_cnt_q <= '0;
            end else if (state_q == RUN) begin
                win_cnt_q <= win_cnt_q + WindowWidth'(1);
            end
        end
    end

    axi_rt_bw_counter #(
        .CountWidth(CountWidth)
    ) u_r_counter (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .run_i    (running),
        .beat_i   (r_beat),
        .close_i  (close),
        .clear_i  (clear_i),
        .inc_i    (r_inc),
        .thresh_i (r_thresh_i),
        .bytes_o  (r_bytes_o),
        .overrun_o(r_overrun_o)
    );

    axi_rt_bw_counter #(
        .CountWidth(CountWidth)
    ) u_w_counter (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .run_i    (running),
        .beat_i   (w_beat),
        .close_i  (close),
        .clear_i  (clear_i),
        .inc_i    (w_inc),
        .thresh_i (w_thresh_i),
        .bytes_o  (w_bytes_o),
        .overrun_o(w_overrun_o)
    );

    assign active_o      = (state_q == RUN);
    assign window_done_o = done_q;

endmodule

// File: tb/tb_axi_rt_bw_monitor.sv
// Bench for axi_rt_bw_monitor (64-bit data, 8-bit counters) against a window-sum model.
// Honours AXI_RT_BW_MON_STRB_EN for the expected write byte counts.
module tb_axi_rt_bw_monitor;
    import axi_rt_bw_mon_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    mon_req_t    req;
    mon_resp_t   resp;
    logic        enable_i;
    logic [15:0] window_i;
    logic [7:0]  r_thresh_i;
    logic [7:0]  w_thresh_i;
    logic        clear_i;
    logic        active_o;
    logic        window_done_o;
    logic [7:0]  r_bytes_o;
    logic [7:0]  w_bytes_o;
    logic        r_overrun_o;
    logic        w_overrun_o;

    int tests = 0;
    int fails = 0;
    int last_r = 0;
    int last_w = 0;
    logic r_ov_m = 1'b0;
    logic w_ov_m = 1'b0;
    logic [7:0] strb_seq[$];

    always #5 clk_i = ~clk_i;

    axi_rt_bw_monitor #(
        .DataWidth  (64),
        .WindowWidth(16),
        .CountWidth (8),
        .axi_req_t  (mon_req_t),
        .axi_resp_t (mon_resp_t)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_i        (req),
        .resp_i       (resp),
        .enable_i     (enable_i),
        .window_i     (window_i),
        .r_thresh_i   (r_thresh_i),
        .w_thresh_i   (w_thresh_i),
        .clear_i      (clear_i),
        .active_o     (active_o),
        .window_done_o(window_done_o),
        .r_bytes_o    (r_bytes_o),
        .w_bytes_o    (w_bytes_o),
        .r_overrun_o  (r_overrun_o),
        .w_overrun_o  (w_overrun_o)
    );

    task automatic step;
        @(negedge clk_i);
    endtask

    task automatic drive_idle;
        req     = '0;
        resp    = '0;
        clear_i = 1'b0;
    endtask

    // Handshake when requested; otherwise a stall (valid without ready) or random non-handshake.
    task automatic drive_beat(input logic rh, input logic wh, input logic stall, input logic [7:0] s);
        int unsigned c;
        req.w.strb = s;
        if (rh) {resp.r_valid, req.r_ready} = 2'b11;
        else if (stall) {resp.r_valid, req.r_ready} = 2'b10;
        else begin
            c = $urandom_range(0, 2);
            {resp.r_valid, req.r_ready} = 2'(c);
        end
        if (wh) {req.w_valid, resp.w_ready} = 2'b11;
        else if (stall) {req.w_valid, resp.w_ready} = 2'b10;
        else begin
            c = $urandom_range(0, 2);
            {req.w_valid, resp.w_ready} = 2'(c);
        end
    endtask

    // One full window of n cycles with handshakes where the masks have a 1.
    task automatic run_window(input string tag, input int n, input logic [63:0] rmask,
                              input logic [63:0] wmask, input logic stall, input int clr_k);
        int r_acc = 0;
        int w_acc = 0;
        int inc;
        logic [7:0] s;
        logic fin;
        logic exp_act;
        for (int k = 0; k < n; k++) begin
            if (wmask[k] && strb_seq.size() > 0) s = strb_seq.pop_front();
            else s = 8'($urandom);
            drive_beat(rmask[k], wmask[k], stall, s);
            clear_i = (k == clr_k);
`ifdef AXI_RT_BW_MON_STRB_EN
            inc = $countones(s);
`else
            inc = 8;
`endif
            if (rmask[k]) r_acc = (r_acc + 8 > 255) ? 255 : r_acc + 8;
            if (wmask[k]) w_acc = (w_acc + inc > 255) ? 255 : w_acc + inc;
            r_ov_m = ((r_thresh_i != 0) && (r_acc > int'(r_thresh_i))) || (r_ov_m && !clear_i);
            w_ov_m = ((w_thresh_i != 0) && (w_acc > int'(w_thresh_i))) || (w_ov_m && !clear_i);
            step;
            fin = (k == n - 1);
            exp_act = !fin || (window_i != 0);
            if (fin) begin
                last_r = r_acc;
                last_w = w_acc;
            end
            tests++;
            if (window_done_o !== fin) begin
                $display("FAIL %s done k=%0d: got %b want %b", tag, k, window_done_o, fin);
                fails++;
            end
            tests++;
            if (active_o !== exp_act) begin
                $display("FAIL %s active k=%0d: got %b want %b", tag, k, active_o, exp_act);
                fails++;
            end
            tests++;
            if (r_overrun_o !== r_ov_m || w_overrun_o !== w_ov_m) begin
                $display("FAIL %s overrun k=%0d: got r%b w%b want r%b w%b", tag, k,
                         r_overrun_o, w_overrun_o, r_ov_m, w_ov_m);
                fails++;
            end
            tests++;
            if (r_bytes_o !== 8'(last_r) || w_bytes_o !== 8'(last_w)) begin
                $display("FAIL %s bytes k=%0d: got r%0d w%0d want r%0d w%0d", tag, k,
                         r_bytes_o, w_bytes_o, last_r, last_w);
                fails++;
            end
        end
        drive_idle;
    endtask

    // Entry cycle: a handshake here belongs to no window.
    task automatic start_run(input int win);
        window_i = 16'(win);
        enable_i = 1'b1;
        drive_beat(1'b1, 1'b1, 1'b0, 8'hFF);
        step;
        drive_idle;
        tests++;
        if (active_o !== 1'b1 || window_done_o !== 1'b0) begin
            $display("FAIL start: got active %b done %b want 1 0", active_o, window_done_o);
            fails++;
        end
        tests++;
        if (r_overrun_o !== r_ov_m || w_overrun_o !== w_ov_m) begin
            $display("FAIL start overrun: got r%b w%b want r%b w%b", r_overrun_o, w_overrun_o, r_ov_m, w_ov_m);
            fails++;
        end
    endtask

    task automatic stop_run;
        enable_i = 1'b0;
        drive_beat(1'b1, 1'b1, 1'b0, 8'hFF);
        step;
        drive_idle;
        tests++;
        if (active_o !== 1'b0 || window_done_o !== 1'b0) begin
            $display("FAIL stop: got active %b done %b want 0 0", active_o, window_done_o);
            fails++;
        end
        tests++;
        if (r_bytes_o !== 8'(last_r) || w_bytes_o !== 8'(last_w)) begin
            $display("FAIL stop hold: got r%0d w%0d want r%0d w%0d", r_bytes_o, w_bytes_o, last_r, last_w);
            fails++;
        end
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        enable_i = 1'b1;
        window_i = 16'd5;
        r_thresh_i = 8'd0;
        w_thresh_i = 8'd0;
        drive_beat(1'b1, 1'b1, 1'b0, 8'hFF);
        repeat (3) step;
        tests++;
        if ({active_o, window_done_o, r_bytes_o, w_bytes_o, r_overrun_o, w_overrun_o} !== 20'd0) begin
            $display("FAIL reset: got act%b done%b r%0d w%0d ovr%b ovw%b want all 0", active_o,
                     window_done_o, r_bytes_o, w_bytes_o, r_overrun_o, w_overrun_o);
            fails++;
        end
        enable_i = 1'b0;
        drive_idle;
        rst_ni = 1'b1;
        step;
        tests++;
        if (active_o !== 1'b0) begin
            $display("FAIL reset idle: got active %b want 0", active_o);
            fails++;
        end
    endtask

    task automatic test_basic;
        start_run(10);
        run_window("basic", 10, 64'h092, 64'h0, 1'b0, -1);
        tests++;
        if (r_bytes_o !== 8'd24 || w_bytes_o !== 8'd0) begin
            $display("FAIL basic 3 reads: got r%0d w%0d want r24 w0", r_bytes_o, w_bytes_o);
            fails++;
        end
        run_window("basic2", 10, 64'($urandom) & 64'h3FF, 64'($urandom) & 64'h3FF, 1'b0, -1);
        stop_run;
    endtask

    task automatic test_overrun;
        r_thresh_i = 8'd16;
        start_run(10);
        run_window("ovr_set", 10, 64'h049, 64'h0, 1'b0, -1);
        tests++;
        if (r_overrun_o !== 1'b1) begin
            $display("FAIL ovr sticky: got %b want 1", r_overrun_o);
            fails++;
        end
        run_window("ovr_hold", 10, 64'h0, 64'h0, 1'b0, -1);
        run_window("ovr_clear", 10, 64'h0, 64'h0, 1'b0, 2);
        run_window("ovr_setwins", 10, 64'h007, 64'h0, 1'b0, 2);
        stop_run;
        clear_i = 1'b1;
        r_ov_m = 1'b0;
        w_ov_m = 1'b0;
        step;
        clear_i = 1'b0;
        tests++;
        if (r_overrun_o !== 1'b0) begin
            $display("FAIL ovr idle clear: got %b want 0", r_overrun_o);
            fails++;
        end
        r_thresh_i = 8'd0;
    endtask

    task automatic test_stall_last;
        start_run(10);
        run_window("stall_last", 10, 64'h200, 64'h0, 1'b1, -1);
        tests++;
        if (r_bytes_o !== 8'd8) begin
            $display("FAIL stall last beat: got %0d want 8", r_bytes_o);
            fails++;
        end
        run_window("stall_next", 10, 64'h0, 64'h0, 1'b1, -1);
        stop_run;
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 40; i++) strb_seq.push_back(8'hFF);
        start_run(40);
        run_window("sat", 40, 64'h0, 64'hFF_FFFF_FFFF, 1'b0, -1);
        tests++;
        if (w_bytes_o !== 8'd255) begin
            $display("FAIL saturation: got %0d want 255", w_bytes_o);
            fails++;
        end
        stop_run;
    endtask

    task automatic test_strb;
        logic [7:0] want;
`ifdef AXI_RT_BW_MON_STRB_EN
        want = 8'd12;
`else
        want = 8'd16;
`endif
        strb_seq.push_back(8'h0F);
        strb_seq.push_back(8'hFF);
        start_run(4);
        run_window("strb", 4, 64'h0, 64'h3, 1'b0, -1);
        tests++;
        if (w_bytes_o !== want) begin
            $display("FAIL strb bytes: got %0d want %0d", w_bytes_o, want);
            fails++;
        end
        stop_run;
    endtask

    task automatic test_disable;
        start_run(10);
        run_window("dis_pre", 10, 64'h005, 64'h0, 1'b0, -1);
        for (int k = 0; k < 2; k++) begin
            drive_beat(1'b1, 1'b0, 1'b0, 8'hFF);
            step;
            tests++;
            if (window_done_o !== 1'b0 || r_bytes_o !== 8'(last_r)) begin
                $display("FAIL dis partial k=%0d: got done %b r%0d want 0 r%0d", k, window_done_o, r_bytes_o, last_r);
                fails++;
            end
        end
        stop_run;
        start_run(10);
        run_window("dis_fresh", 10, 64'h001, 64'h0, 1'b0, -1);
        tests++;
        if (r_bytes_o !== 8'd8) begin
            $display("FAIL dis fresh window: got %0d want 8", r_bytes_o);
            fails++;
        end
        stop_run;
    endtask

    task automatic test_window_change;
        start_run(6);
        window_i = 16'd3;
        run_window("wchg_old", 6, 64'h3F, 64'h0, 1'b0, -1);
        run_window("wchg_new", 3, 64'h7, 64'h5, 1'b0, -1);
        window_i = 16'd0;
        run_window("wchg_zero", 3, 64'h1, 64'h2, 1'b0, -1);
        step;
        tests++;
        if (active_o !== 1'b0 || window_done_o !== 1'b0) begin
            $display("FAIL wchg idle: got active %b done %b want 0 0", active_o, window_done_o);
            fails++;
        end
        enable_i = 1'b0;
    endtask

    task automatic test_random;
        int cur;
        int nxt;
        int clr;
        r_thresh_i = 8'($urandom_range(1, 200));
        w_thresh_i = 8'($urandom_range(1, 200));
        cur = $urandom_range(1, 48);
        start_run(cur);
        for (int w = 0; w < 10; w++) begin
            nxt = $urandom_range(1, 48);
            window_i = 16'(nxt);
            clr = $urandom_range(0, 1) ? $urandom_range(0, cur - 1) : -1;
            run_window("rand", cur, {$urandom, $urandom} | {$urandom, $urandom},
                       {$urandom, $urandom} & {$urandom, $urandom}, 1'($urandom), clr);
            cur = nxt;
        end
        stop_run;
        r_thresh_i = 8'd0;
        w_thresh_i = 8'd0;
    endtask

    task automatic test_async_reset;
        r_thresh_i = 8'd8;
        start_run(10);
        run_window("arst_pre", 10, 64'h003, 64'h003, 1'b0, -1);
        drive_beat(1'b1, 1'b1, 1'b0, 8'hFF);
        step;
        #2;
        rst_ni = 1'b0;
        #1;
        tests++;
        if ({active_o, window_done_o, r_bytes_o, w_bytes_o, r_overrun_o, w_overrun_o} !== 20'd0) begin
            $display("FAIL async reset: got act%b done%b r%0d w%0d ovr%b ovw%b want all 0", active_o,
                     window_done_o, r_bytes_o, w_bytes_o, r_overrun_o, w_overrun_o);
            fails++;
        end
        step;
        enable_i = 1'b0;
        drive_idle;
        r_thresh_i = 8'd0;
        rst_ni = 1'b1;
        last_r = 0;
        last_w = 0;
        r_ov_m = 1'b0;
        w_ov_m = 1'b0;
        step;
        tests++;
        if (active_o !== 1'b0 || r_bytes_o !== 8'd0 || r_overrun_o !== 1'b0) begin
            $display("FAIL after reset: got act%b r%0d ovr%b want 0 0 0", active_o, r_bytes_o, r_overrun_o);
            fails++;
        end
    endtask

    initial begin
        drive_idle;
        test_reset;
        test_basic;
        test_overrun;
        test_stall_last;
        test_saturation;
        test_strb;
        test_disable;
        test_window_change;
        test_random;
        test_async_reset;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
